// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered, handshaked ALU with a flags register and an
// iterative (one bit per cycle) shifter.
//
// Sits between register-file read and writeback in the 16-bit datapath.
//
// Opcode map:
//   000 ADD   001 SUB   010 AND   011 OR
//   100 XOR   101 SHL   110 SHR (logical)   111 NOT a
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand/opcode presented
//   in_ready   block can accept an operation this cycle
//   op         3-bit opcode (map above)
//   a, b       operands; shifts take the amount from b[SHW-1:0]
//   out_valid  result/flags valid
//   out_ready  consumer accepts the result
//   result     registered result
//   flags      {Z,N,C,V}, registered together with result
//   busy       high while the FSM is in SHIFT (this is also the FSM state
//              observation point: busy==1 <=> state==SHIFT)
//
// Build option:
//   ALU_SAT_EN  when defined, ADD/SUB saturate to the signed range; V still
//               reports the overflow, C comes from the unsaturated sum and
//               Z/N from the saturated result. Undefined: ADD/SUB wrap.
//
// Handshake rules (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   The producer holds its payload stable while valid && !ready. On the
//   output side, result/flags stay frozen while out_valid && !out_ready, and
//   in_ready is only high in IDLE with the output slot free or draining this
//   cycle, so a consume and a new accept may share one edge.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;

    // Counter is one bit wider than the amount field so it can hold WIDTH
    // itself when the amount is clamped.
    localparam logic [SHW:0] AMT_MAX = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] work_q;
    logic [SHW:0]     cnt_q;
    logic             shr_q;

    logic             accept;
    logic             is_shift;
    logic [SHW:0]     amt_raw;
    logic [SHW:0]     amt;
    logic             shift_start;
    logic             last_step;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             ovf_add;
    logic             ovf_sub;
    logic [WIDTH-1:0] res_c;
    logic             c_c;
    logic             v_c;
    logic [3:0]       flags_c;

    logic [WIDTH-1:0] work_next;
    logic             bit_out;

    // ---------------------------------------------------------------------
    // Acceptance and shift-amount decode
    // ---------------------------------------------------------------------
    assign accept   = in_valid && in_ready;
    assign is_shift = (op == OP_SHL) || (op == OP_SHR);
    assign amt_raw  = {1'b0, b[SHW-1:0]};
    // Only reachable when WIDTH is not a power of two.
    assign amt      = (amt_raw > AMT_MAX) ? AMT_MAX : amt_raw;

    // A zero-amount shift completes like a single-cycle op and never
    // enters SHIFT.
    assign shift_start = accept && is_shift && (amt != '0);

    // The step that takes the counter from 1 to 0 is the one that writes
    // the result, giving amt+1 cycles of total latency.
    assign last_step = (state_q == SHIFT) && (cnt_q <= CNT_ONE);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (shift_start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready = (state_q == IDLE) && (!out_valid || out_ready);
        busy     = (state_q == SHIFT);
    end

    // ---------------------------------------------------------------------
    // Single-cycle datapath
    // ---------------------------------------------------------------------
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    // Overflow: result sign differs from a's sign when the operands (ADD)
    // or a and ~b (SUB) agree in sign.
    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1]  != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_SAT_EN
    logic [WIDTH-1:0] sat_val;
    // On overflow the true result has the sign of a in both ADD and SUB.
    assign sat_val = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
`endif

    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        case (op)
            OP_ADD: begin
                res_c = sum_ext[WIDTH-1:0];
                c_c   = sum_ext[WIDTH];
                v_c   = ovf_add;
`ifdef ALU_SAT_EN
                if (ovf_add) begin
                    res_c = sat_val;
                end
`endif
            end
            OP_SUB: begin
                res_c = diff_ext[WIDTH-1:0];
                c_c   = diff_ext[WIDTH];   // borrow: a < b unsigned
                v_c   = ovf_sub;
`ifdef ALU_SAT_EN
                if (ovf_sub) begin
                    res_c = sat_val;
                end
`endif
            end
            OP_AND: res_c = a & b;
            OP_OR:  res_c = a | b;
            OP_XOR: res_c = a ^ b;
            // Only used for a zero shift amount: result is a, nothing
            // shifted out.
            OP_SHL, OP_SHR: res_c = a;
            // 111 and any unknown opcode behave as NOT.
            default: res_c = ~a;
        endcase
        flags_c = {(res_c == '0), res_c[WIDTH-1], c_c, v_c};
    end

    // ---------------------------------------------------------------------
    // Iterative shifter step
    // ---------------------------------------------------------------------
    always_comb begin
        if (shr_q) begin
            work_next = {1'b0, work_q[WIDTH-1:1]};
            bit_out   = work_q[0];
        end else begin
            work_next = {work_q[WIDTH-2:0], 1'b0};
            bit_out   = work_q[WIDTH-1];
        end
    end

    // ---------------------------------------------------------------------
    // Shifter working registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            cnt_q  <= '0;
            shr_q  <= 1'b0;
        end else if (shift_start) begin
            work_q <= a;
            cnt_q  <= amt;
            shr_q  <= (op == OP_SHR);
        end else if (state_q == SHIFT) begin
            work_q <= work_next;
            cnt_q  <= cnt_q - CNT_ONE;
        end
    end

    // ---------------------------------------------------------------------
    // Output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else if (accept && !shift_start) begin
            result    <= res_c;
            flags     <= flags_c;
            out_valid <= 1'b1;
        end else if (last_step) begin
            // Final shift bit goes straight into C; V is always 0 for shifts.
            result    <= work_next;
            flags     <= {(work_next == '0), work_next[WIDTH-1], bit_out, 1'b0};
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W  = 8;
  localparam int SW = $clog2(W);

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  logic [W+3:0] exp_q[$];   // {result, Z, N, C, V}
  int           lat_q[$];
  int           acc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: plain integer arithmetic on the opcode rules
  // ---------------------------------------------------------------------
  function automatic logic [W+3:0] model(input logic [2:0] o, input int x, input int y,
                                         output int lat);
    int mask, half, sx, sy, s, r, c, v, amt;
    logic [W-1:0] rr;
    mask = (1 << W) - 1;
    half = 1 << (W - 1);
    sx   = (x >= half) ? x - (1 << W) : x;
    sy   = (y >= half) ? y - (1 << W) : y;
    amt  = y % (1 << SW);
    if (amt > W) amt = W;
    lat = 1;
    r = 0; c = 0; v = 0;
    case (o)
      3'd0: begin
        r = (x + y) & mask;
        c = (x + y > mask) ? 1 : 0;
        s = sx + sy;
        v = (s > half - 1 || s < -half) ? 1 : 0;
`ifdef ALU_SAT_EN
        if (v != 0) r = (s > 0) ? half - 1 : half;
`endif
      end
      3'd1: begin
        r = (x - y) & mask;
        c = (x < y) ? 1 : 0;
        s = sx - sy;
        v = (s > half - 1 || s < -half) ? 1 : 0;
`ifdef ALU_SAT_EN
        if (v != 0) r = (s > 0) ? half - 1 : half;
`endif
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin
        r   = (x << amt) & mask;
        c   = (amt == 0) ? 0 : ((x >> (W - amt)) & 1);
        lat = amt + 1;
      end
      3'd6: begin
        r   = x >> amt;
        c   = (amt == 0) ? 0 : ((x >> (amt - 1)) & 1);
        lat = amt + 1;
      end
      default: r = (~x) & mask;
    endcase
    rr = r[W-1:0];
    return {rr, (rr == '0), rr[W-1], c[0], v[0]};
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W+3:0] e, input int lat, output int waits);
    op = o; a = x; b = y; in_valid = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!in_ready && waits < 200);
    if (!in_ready) begin
      chk("accept_timeout", {31'd0, in_ready}, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      lat_q.push_back(lat);
      acc_q.push_back(cyc + 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic issue_rand();
    logic [2:0]   o;
    logic [W-1:0] x, y;
    logic [W+3:0] e;
    int           lat, w;
    o = 3'($urandom_range(0, 7));
    x = W'($urandom_range(0, (1 << W) - 1));
    y = W'($urandom_range(0, (1 << W) - 1));
    e = model(o, int'(x), int'(y), lat);
    issue(o, x, y, e, lat, w);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------------
  // Random output backpressure
  // ---------------------------------------------------------------------
  bit rand_bp = 1'b0;
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------------------------------------------------------------
  // Monitor: compares every presented output against the queue head
  // ---------------------------------------------------------------------
  bit held = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (busy) chk("busy_blocks_ready", {31'd0, in_ready}, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", {31'd0, out_valid}, 0);
        end else begin
          chk("result_flags", {20'd0, result, flags}, {20'd0, exp_q[0]});
          if (!held) chk("latency", cyc - acc_q[0] + 1, lat_q[0]);
          if (!out_ready) chk("hold_ready_low", {31'd0, in_ready}, 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
        held = !out_ready;
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int w, n;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_result", {24'd0, result}, 0);
    chk("rst_flags", {28'd0, flags}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;

    // Directed arithmetic / logic
    out_ready = 1'b1;
    issue(3'd0, 8'hFF, 8'h01, {8'h00, 4'b1010}, 1, w);
    issue(3'd1, 8'h80, 8'h01, {8'h7F, 4'b0001}, 1, w);
    issue(3'd1, 8'h01, 8'h02, {8'hFF, 4'b0110}, 1, w);

    // SHL by 3: busy and not ready for 3 cycles, result on the 4th
    issue(3'd5, 8'h81, 8'h03, {8'h08, 4'b0000}, 4, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("shl_busy", {31'd0, busy}, 1);
      chk("shl_in_ready", {31'd0, in_ready}, 0);
    end
    @(negedge clk);
    chk("shl_done_busy", {31'd0, busy}, 0);
    chk("shl_done_valid", {31'd0, out_valid}, 1);
    @(posedge clk); #1;

    issue(3'd6, 8'h81, 8'h01, {8'h40, 4'b0010}, 2, w);
    issue(3'd7, 8'h00, 8'h5A, {8'hFF, 4'b0100}, 1, w);
    issue(3'd4, 8'hAA, 8'hAA, {8'h00, 4'b1000}, 1, w);
    issue(3'd6, 8'h55, 8'h00, {8'h55, 4'b0000}, 1, w);
    issue(3'd5, 8'h01, 8'h07, {8'h80, 4'b0100}, 8, w);
`ifdef ALU_SAT_EN
    issue(3'd0, 8'h70, 8'h20, {8'h7F, 4'b0001}, 1, w);
`else
    issue(3'd0, 8'h70, 8'h20, {8'h90, 4'b0101}, 1, w);
`endif
    wait_drain();

    // Backpressure: hold the AND result, then consume and accept OR together
    out_ready = 1'b0;
    issue(3'd2, 8'hF0, 8'h3C, {8'h30, 4'b0000}, 1, w);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", {31'd0, out_valid}, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_stable", {20'd0, result, flags}, {20'd0, 8'h30, 4'b0000});
      chk("bp_in_ready", {31'd0, in_ready}, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(3'd3, 8'h30, 8'h0F, {8'h3F, 4'b0000}, 1, w);
    chk("back_to_back_wait", w, 1);
    wait_drain();

    // Reset in the middle of a shift
    issue(3'd5, 8'h03, 8'h07, {8'h80, 4'b0110}, 8, w);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("midshift_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
    #1;
    chk("midshift_rst_valid", {31'd0, out_valid}, 0);
    chk("midshift_rst_busy", {31'd0, busy}, 0);
    chk("midshift_rst_result", {24'd0, result}, 0);
    chk("midshift_rst_flags", {28'd0, flags}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midshift_rel_ready", {31'd0, in_ready}, 1);
    chk("midshift_rel_valid", {31'd0, out_valid}, 0);
    @(posedge clk); #1;

    // Randomized traffic with random output backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) issue_rand();
    rand_bp = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the team's combinational 8-op ALU.
- Keeps the same 3-bit opcode map and adds three things: valid/ready handshakes on input and output, a Z/N/C/V flags register, and an iterative multi-bit shifter that runs one bit per cycle.
- Sits between the register-file read stage and the writeback stage of the 16-bit processor datapath.

Parameters:
- WIDTH, 16, operand/result width in bits (min 4).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 NOT a.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; shifts use b[SHW-1:0] as the amount.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- flags  output  4  {Z,N,C,V}, registered together with result.
- busy  output  1  high while the FSM is in SHIFT.

Behaviour:
- Reset (async assert, sync deassert at the bench): state=IDLE, out_valid=0, result=0, flags=0, busy=0, shift counter=0. Reset mid-SHIFT aborts the operation and loses it.
- Handshake and acceptance:
  - Accept occurs on in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Consuming a result and accepting a new op in the same cycle is legal.
- FSM states: IDLE, SHIFT.
- Single-cycle ops (000-100, 111):
  - Result is registered on the accept edge, so out_valid=1 the next cycle (latency 1).
  - The FSM stays in IDLE.
- Shifts (101/110):
  - Accept loads a into the work register and amt=b[SHW-1:0].
  - amt is clamped to WIDTH when WIDTH is not a power of two.
  - If amt==0: latency 1, result=a, C=0.
  - Otherwise: go to SHIFT; each cycle shift by 1 and decrement the counter. When the counter reaches 0, write result/flags, assert out_valid, and return to IDLE.
  - Total latency is amt+1 cycles. in_ready=0 and busy=1 throughout SHIFT.
- Arithmetic (modulo 2^WIDTH):
  - ADD: C=carry out; V=signed overflow.
  - SUB (a-b): C=borrow (1 when a<b unsigned); V=signed overflow.
  - SHL/SHR: C=last bit shifted out; V=0.
  - Logic ops and NOT: C=0, V=0.
  - All ops: Z=(result==0); N=result[WIDTH-1].
- Output hold: while out_valid && !out_ready, result and flags are held stable and no new accept occurs.
- out_valid clears on out_ready unless a new single-cycle op is accepted in the same cycle.
- Undriven/X op: treated as NOT for synthesis; the bench never drives it.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: ADD/SUB saturate to the signed range: overflow positive gives 0111..1, overflow negative gives 1000..0. V still reports overflow. C is computed from the unsaturated sum. Z/N are computed from the saturated result.
- Undefined: ADD/SUB wrap modulo 2^WIDTH. No extra logic.

Test Plan:
- WIDTH=8, ADD a=0xFF b=0x01, out_ready=1 -> result=0x00, flags Z=1 N=0 C=1 V=0, out_valid 1 cycle after accept.
- SUB a=0x80 b=0x01 -> result=0x7F, Z=0 N=0 C=0 V=1. Then SUB a=0x01 b=0x02 -> result=0xFF, C=1 N=1 V=0.
- SHL a=0x81 b=3 -> busy=1 and in_ready=0 for 3 cycles; result=0x08, C=0, out_valid 4 cycles after accept. SHR a=0x81 b=1 -> 0x40, C=1, latency 2.
- Backpressure: complete AND 0xF0&0x3C=0x30, hold out_ready=0 for 5 cycles -> result/flags stable, in_ready=0. Raise out_ready together with a new OR op -> back-to-back accept; next result 0x30|0x0F=0x3F.
- Reset mid-shift: start SHL b=7, pull rst_n low on the 3rd SHIFT cycle -> out_valid=0, busy=0, result=0 immediately; in_ready=1 after release.
- With ALU_SAT_EN, ADD 0x70+0x20 -> result=0x7F, V=1. Without it -> result=0x90, V=1, N=1.
